// File: rtl/gbe_pkg.sv
// -----------------------------------------------------------------------------
// gbe_pkg
// Shared definitions for the 10GbE transmit packetizer: FSM state encoding,
// word / header field widths and the header-word builder.
// -----------------------------------------------------------------------------
package gbe_pkg;

  localparam int WORD_W     = 64;  // payload / transmit word width
  localparam int PKT_CNT_W  = 48;  // frame counter field in the header
  localparam int SRC_ID_W   = 16;  // source identifier field in the header
  localparam int OVF_CNT_W  = 16;  // overflow cycle counter width
  localparam int WORD_CNT_W = 11;  // payload word index, covers up to 1024 words

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HEADER,
    ST_PAYLOAD
  } state_t;

  // Header word layout: frame number in the upper bits, source id in the lower.
  function automatic logic [WORD_W-1:0] header_word(
    input logic [PKT_CNT_W-1:0] pkt,
    input logic [SRC_ID_W-1:0]  src
  );
    return {pkt, src};
  endfunction

endpackage

// File: rtl/gbe_tx_packetizer_if.sv
// -----------------------------------------------------------------------------
// gbe_tx_packetizer_if
// Bundles the upstream payload handshake and the 10GbE core transmit port.
//   in_valid / in_data / in_ready : upstream word stream (ready from packetizer)
//   tx_valid / tx_data / tx_end_of_frame : words toward the core
//   tx_afull / tx_overflow : core transmit buffer status
// Modports:
//   master : the packetizer side
//   slave  : the environment (upstream source + core)
// -----------------------------------------------------------------------------
interface gbe_tx_packetizer_if;
  import gbe_pkg::*;

  logic              in_valid;
  logic [WORD_W-1:0] in_data;
  logic              in_ready;
  logic              tx_valid;
  logic [WORD_W-1:0] tx_data;
  logic              tx_end_of_frame;
  logic              tx_afull;
  logic              tx_overflow;

  modport master (
    input  in_valid, in_data, tx_afull, tx_overflow,
    output in_ready, tx_valid, tx_data, tx_end_of_frame
  );

  modport slave (
    output in_valid, in_data, tx_afull, tx_overflow,
    input  in_ready, tx_valid, tx_data, tx_end_of_frame
  );

endinterface

// File: rtl/gbe_tx_packetizer.sv
// -----------------------------------------------------------------------------
// gbe_tx_packetizer
// Wraps PAYLOAD_WORDS upstream 64-bit words into a frame preceded by one
// header word {pkt_cnt, SRC_ID} and streams it to a 10GbE core transmit port.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   en            : start a frame (looked at only while idle)
//   bus (master)  : upstream handshake + core transmit port
//   tx_dest_ip    : constant DEST_IP
//   tx_dest_port  : constant DEST_PORT
//   pkt_cnt       : frames fully emitted since reset (wraps)
//   ovf_cnt       : cycles with tx_overflow high (saturating)
//   ovf_flag      : sticky overflow indicator
// -----------------------------------------------------------------------------
import gbe_pkg::*;

module gbe_tx_packetizer #(
  parameter int          PAYLOAD_WORDS = 128,
  parameter logic [15:0] SRC_ID        = 16'h0000,
  parameter logic [31:0] DEST_IP       = 32'hC0A8050A,
  parameter logic [15:0] DEST_PORT     = 16'h2710
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  gbe_tx_packetizer_if.master   bus,
  output logic [31:0]           tx_dest_ip,
  output logic [15:0]           tx_dest_port,
  output logic [PKT_CNT_W-1:0]  pkt_cnt,
  output logic [OVF_CNT_W-1:0]  ovf_cnt,
  output logic                  ovf_flag
);

  localparam logic [WORD_CNT_W-1:0] LAST_IDX = WORD_CNT_W'(PAYLOAD_WORDS - 1);

  state_t                 state_q, state_d;
  logic [WORD_CNT_W-1:0]  word_cnt_q, word_cnt_d;
  logic [PKT_CNT_W-1:0]   pkt_cnt_q, pkt_cnt_d;
  logic [OVF_CNT_W-1:0]   ovf_cnt_q, ovf_cnt_d;
  logic                   ovf_flag_q, ovf_flag_d;
  logic                   tx_valid_q, tx_valid_d;
  logic                   tx_eof_q, tx_eof_d;
  logic [WORD_W-1:0]      tx_data_q, tx_data_d;
  logic                   in_ready_c;
  logic                   accept_c;

  // Gated with rst so upstream never sees a handshake while reset is applied.
  assign in_ready_c = (state_q == ST_PAYLOAD) && !bus.tx_afull && !rst;
  assign accept_c   = in_ready_c && bus.in_valid;

  always_comb begin
    state_d    = state_q;
    word_cnt_d = word_cnt_q;
    pkt_cnt_d  = pkt_cnt_q;
    tx_valid_d = 1'b0;
    tx_eof_d   = 1'b0;
    tx_data_d  = tx_data_q;   // data holds between valid words

    case (state_q)
      ST_IDLE: begin
        if (en) state_d = ST_HEADER;
      end
      ST_HEADER: begin
        if (!bus.tx_afull) begin
          tx_valid_d = 1'b1;
          tx_data_d  = header_word(pkt_cnt_q, SRC_ID);
          word_cnt_d = '0;
          state_d    = ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        if (accept_c) begin
          tx_valid_d = 1'b1;
          tx_data_d  = bus.in_data;
          if (word_cnt_q == LAST_IDX) begin
            // Frame counter advances together with the end-of-frame word.
            tx_eof_d   = 1'b1;
            pkt_cnt_d  = pkt_cnt_q + 48'd1;
            word_cnt_d = '0;
            state_d    = ST_IDLE;
          end else begin
            word_cnt_d = word_cnt_q + 11'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    ovf_cnt_d  = ovf_cnt_q;
    if (bus.tx_overflow && (ovf_cnt_q != '1)) ovf_cnt_d = ovf_cnt_q + 16'd1;
    ovf_flag_d = ovf_flag_q || bus.tx_overflow;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      word_cnt_q <= '0;
      pkt_cnt_q  <= '0;
      ovf_cnt_q  <= '0;
      ovf_flag_q <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_eof_q   <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
      pkt_cnt_q  <= pkt_cnt_d;
      ovf_cnt_q  <= ovf_cnt_d;
      ovf_flag_q <= ovf_flag_d;
      tx_valid_q <= tx_valid_d;
      tx_eof_q   <= tx_eof_d;
      tx_data_q  <= tx_data_d;
    end
  end

  assign bus.in_ready        = in_ready_c;
  assign bus.tx_valid        = tx_valid_q;
  assign bus.tx_data         = tx_data_q;
  assign bus.tx_end_of_frame = tx_eof_q;
  assign tx_dest_ip          = DEST_IP;
  assign tx_dest_port        = DEST_PORT;
  assign pkt_cnt             = pkt_cnt_q;
  assign ovf_cnt             = ovf_cnt_q;
  assign ovf_flag            = ovf_flag_q;

endmodule

// File: tb/tb_gbe_tx_packetizer.sv
// -----------------------------------------------------------------------------
// tb_gbe_tx_packetizer
// Directed and randomized stimulus against a transaction-level frame model:
// the model tracks whether a frame is open, whether its header is still owed,
// how many payload words remain, and the frame / overflow counters.
// -----------------------------------------------------------------------------
module tb_gbe_tx_packetizer;

  localparam int          PW  = 4;
  localparam logic [15:0] SRC = 16'h00AB;
  localparam logic [31:0] DIP = 32'hC0A8050A;
  localparam logic [15:0] DPT = 16'h2710;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [31:0] tx_dest_ip;
  logic [15:0] tx_dest_port;
  logic [47:0] pkt_cnt;
  logic [15:0] ovf_cnt;
  logic        ovf_flag;

  gbe_tx_packetizer_if bus();

  gbe_tx_packetizer #(
    .PAYLOAD_WORDS(PW),
    .SRC_ID       (SRC),
    .DEST_IP      (DIP),
    .DEST_PORT    (DPT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .bus         (bus.master),
    .tx_dest_ip  (tx_dest_ip),
    .tx_dest_port(tx_dest_port),
    .pkt_cnt     (pkt_cnt),
    .ovf_cnt     (ovf_cnt),
    .ovf_flag    (ovf_flag)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state
  bit          m_active;
  bit          m_hdr;
  int          m_left;
  logic [47:0] m_pkt;
  logic [15:0] m_ovf;
  bit          m_flag;

  // Upstream source
  bit          seq_mode;
  logic [63:0] cur_word;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: apply inputs, check combinational ready, advance model,
  // clock, then check registered outputs and counters.
  task automatic step(input bit r, input bit e, input bit v, input bit af,
                      input bit ov, input bit chk);
    bit          exp_rdy, exp_v, exp_eof, acc;
    logic [63:0] exp_d;
    rst = r; en = e;
    bus.in_valid = v; bus.in_data = cur_word;
    bus.tx_afull = af; bus.tx_overflow = ov;
    #1;
    exp_rdy = !r && m_active && !m_hdr && !af;
    if (chk) check("in_ready", {63'd0, bus.in_ready}, {63'd0, exp_rdy});
    exp_v = 0; exp_eof = 0; exp_d = '0; acc = 0;
    if (r) begin
      m_active = 0; m_hdr = 0; m_left = 0;
      m_pkt = '0; m_ovf = '0; m_flag = 0;
    end else begin
      if (!m_active) begin
        if (e) begin m_active = 1; m_hdr = 1; m_left = PW; end
      end else if (!af) begin
        if (m_hdr) begin
          exp_v = 1; exp_d = {m_pkt, SRC}; m_hdr = 0;
        end else if (v) begin
          exp_v = 1; exp_d = cur_word; acc = 1; m_left--;
          if (m_left == 0) begin
            exp_eof = 1; m_pkt = m_pkt + 48'd1; m_active = 0;
          end
        end
      end
      if (ov) begin
        if (m_ovf != 16'hFFFF) m_ovf = m_ovf + 16'd1;
        m_flag = 1;
      end
    end
    @(posedge clk);
    #1;
    if (chk) begin
      check("tx_valid", {63'd0, bus.tx_valid}, {63'd0, exp_v});
      check("tx_eof", {63'd0, bus.tx_end_of_frame}, {63'd0, exp_eof});
      if (exp_v || r) check("tx_data", bus.tx_data, exp_d);
      check("pkt_cnt", {16'd0, pkt_cnt}, {16'd0, m_pkt});
      check("ovf_cnt", {48'd0, ovf_cnt}, {48'd0, m_ovf});
      check("ovf_flag", {63'd0, ovf_flag}, {63'd0, m_flag});
      if (bus.tx_valid)
        $display("t=%0t tx data=0x%016h eof=%0b pkt_cnt=%0d", $time,
                 bus.tx_data, bus.tx_end_of_frame, pkt_cnt);
    end
    if (acc) cur_word = seq_mode ? cur_word + 64'd1 : {$urandom, $urandom};
  endtask

  initial begin
    rst = 1; en = 0;
    bus.in_valid = 0; bus.in_data = '0; bus.tx_afull = 0; bus.tx_overflow = 0;
    m_active = 0; m_hdr = 0; m_left = 0; m_pkt = '0; m_ovf = '0; m_flag = 0;
    seq_mode = 1; cur_word = 64'd1;

    // Reset state
    step(1, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 1);
    check("dest_ip", {32'd0, tx_dest_ip}, {32'd0, DIP});
    check("dest_port", {48'd0, tx_dest_port}, {48'd0, DPT});

    // Basic frame: header 0xAB then 1,2,3,4
    repeat (6) step(0, 1, 1, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    check("pkt_cnt_after_frame1", {16'd0, pkt_cnt}, 64'd1);

    // Almost-full stall after payload word 2; en dropped mid-frame
    cur_word = 64'd1;
    step(0, 1, 1, 0, 0, 1);
    step(0, 0, 1, 0, 0, 1);
    step(0, 0, 1, 0, 0, 1);
    step(0, 0, 1, 0, 0, 1);
    repeat (3) step(0, 0, 1, 1, 0, 1);
    step(0, 0, 1, 0, 0, 1);
    step(0, 0, 1, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);

    // Alternating in_valid with random data
    seq_mode = 0; cur_word = {$urandom, $urandom};
    step(0, 1, 1, 0, 0, 1);
    step(0, 0, 1, 0, 0, 1);
    for (int i = 0; i < 8; i++) step(0, 0, (i % 2) == 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    check("pkt_cnt_after_frame3", {16'd0, pkt_cnt}, 64'd3);

    // Almost-full coinciding with the last payload word
    step(0, 1, 1, 0, 0, 1);
    repeat (4) step(0, 0, 1, 0, 0, 1);
    step(0, 0, 1, 1, 0, 1);
    step(0, 0, 1, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);

    // Randomized traffic
    for (int i = 0; i < 300; i++)
      step(0, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
           $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0, 1);

    // Reset mid-frame after two payload words, then a clean frame
    step(1, 0, 0, 0, 0, 1);
    step(0, 1, 1, 0, 0, 1);
    repeat (3) step(0, 0, 1, 0, 0, 1);
    step(1, 0, 1, 0, 0, 1);
    check("pkt_cnt_after_abort", {16'd0, pkt_cnt}, 64'd0);
    step(0, 1, 1, 0, 0, 1);
    repeat (5) step(0, 0, 1, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);

    // Overflow counting, stickiness and saturation
    step(1, 0, 0, 0, 0, 1);
    repeat (5) step(0, 0, 0, 0, 1, 1);
    check("ovf_cnt_5", {48'd0, ovf_cnt}, 64'd5);
    repeat (3) step(0, 0, 0, 0, 0, 1);
    check("ovf_flag_sticky", {63'd0, ovf_flag}, 64'd1);
    repeat (70000) step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 1);
    check("ovf_cnt_sat", {48'd0, ovf_cnt}, 64'hFFFF);
    step(1, 0, 0, 0, 0, 1);
    check("ovf_flag_cleared", {63'd0, ovf_flag}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gbe_tx_packetizer.md
GBE_TX_PACKETIZER -- requirements
Module: gbe_tx_packetizer

Interface
REQ-001 Parameter PAYLOAD_WORDS, default 128: 64-bit payload words per frame; legal range 1..1024.
REQ-002 Parameter SRC_ID, default 16'h0000: source identifier carried in the header word.
REQ-003 Parameter DEST_IP, default 32'hC0A8050A: destination IP driven on tx_dest_ip.
REQ-004 Parameter DEST_PORT, default 16'h2710: destination UDP port driven on tx_dest_port.
REQ-005 clk  in  1  sole clock; all logic rising-edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 en  in  1  frame-start enable, sampled only in IDLE.
REQ-008 in_valid  in  1  upstream payload word valid.
REQ-009 in_data  in  64  upstream payload word.
REQ-010 in_ready  out  1  upstream word accepted when in_valid & in_ready.
REQ-011 tx_valid  out  1  word valid to 10GbE core transmit port.
REQ-012 tx_data  out  64  word to core.
REQ-013 tx_end_of_frame  out  1  marks last word of frame.
REQ-014 tx_dest_ip  out  32  constant DEST_IP.
REQ-015 tx_dest_port  out  16  constant DEST_PORT.
REQ-016 tx_afull  in  1  core transmit buffer almost full.
REQ-017 tx_overflow  in  1  core transmit buffer overflowed (single-cycle or level).
REQ-018 pkt_cnt  out  48  frames fully emitted since reset.
REQ-019 ovf_cnt  out  16  cycles with tx_overflow high, saturating.
REQ-020 ovf_flag  out  1  sticky, set by any tx_overflow.

Function
REQ-021 FSM states IDLE, HEADER, PAYLOAD; IDLE->HEADER when en=1; HEADER->PAYLOAD when header word issued; PAYLOAD->IDLE when last payload word issued.
REQ-022 Header word = {pkt_cnt[47:0], SRC_ID[15:0]}, issued in HEADER on the first cycle with tx_afull=0.
REQ-023 in_ready = (state==PAYLOAD) & !tx_afull, combinational; 0 in IDLE and HEADER.
REQ-024 tx_valid, tx_data, tx_end_of_frame registered: accepted word appears on tx_* exactly 1 cycle after acceptance.
REQ-025 tx_valid=1 for one cycle per issued header word and per accepted payload word, 0 otherwise.
REQ-026 Payload word counter counts accepted words 0..PAYLOAD_WORDS-1; tx_end_of_frame=1 with the word where counter = PAYLOAD_WORDS-1, else 0.
REQ-027 in_valid=0 in PAYLOAD: no word issued, state and counter held (gaps inside a frame permitted).
REQ-028 tx_afull=1 in HEADER or PAYLOAD: nothing accepted or issued that cycle; resume on first cycle with tx_afull=0.
REQ-029 tx_afull=1 in the same cycle as the last payload word: word not accepted, no end_of_frame, FSM stays in PAYLOAD.
REQ-030 pkt_cnt increments by 1 in the cycle the end_of_frame word is issued; wraps 2^48-1 -> 0.
REQ-031 en deassert mid-frame has no effect; current frame completes.
REQ-032 ovf_cnt increments each cycle tx_overflow=1, saturates at 16'hFFFF; ovf_flag sets same cycle and clears only on rst.
REQ-033 tx_dest_ip, tx_dest_port constant, independent of state.

Reset
REQ-034 rst=1 on a clock edge: state IDLE, payload counter 0, pkt_cnt 0, ovf_cnt 0, ovf_flag 0, tx_valid 0, tx_end_of_frame 0, tx_data 0.
REQ-035 in_ready=0 during and in first cycle after rst.
REQ-036 rst mid-frame abandons partial frame; no end_of_frame emitted; pkt_cnt not incremented.

Structure
REQ-037 Shared package gbe_pkg holds FSM state enum, header field widths (48/16), word width 64.
REQ-038 No sub-module; single module, FSM plus three counters.

Verification
REQ-039 PAYLOAD_WORDS=4, SRC_ID=16'h00AB, en=1, in_valid=1 continuous, data 1,2,3,4 -> tx_data 0x0000_0000_0000_00AB,1,2,3,4 on consecutive cycles, eof only with 4, pkt_cnt=1.
REQ-040 tx_afull=1 for 3 cycles after word 2 -> no tx_valid for 3 cycles, in_ready=0, then words 3,4 follow; frame length still 5 words.
REQ-041 in_valid toggled 1/0 every cycle mid-frame -> payload order preserved, exactly one eof after 4th accepted word.
REQ-042 Preload pkt_cnt path by running 3 frames -> third header upper 48 bits = 2; pkt_cnt=3; force wrap check by bench counter model at 2^48-1 -> 0.
REQ-043 tx_overflow high 5 cycles -> ovf_cnt=5, ovf_flag=1 until rst; 70000 cycles high -> ovf_cnt=16'hFFFF.
REQ-044 rst asserted after 2 payload words -> next cycle tx_valid=0, state IDLE, pkt_cnt unchanged; next frame header carries pkt_cnt=0.
